// File: rtl/mux_scan_sampler.sv
// Parametrised channel sampler: picks one of CHANNELS words (manual select or
// masked round-robin scan) and presents it on a registered valid/ready stream.
module mux_scan_sampler #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_Data,
  input  logic [SEL_W-1:0]          i_Sel,
  input  logic                      i_Mode,
  input  logic [CHANNELS-1:0]       i_Mask,
  input  logic                      i_Ready,
  output logic [WIDTH-1:0]          o_Data,
  output logic [SEL_W-1:0]          o_Chan,
  output logic                      o_Valid
);

  localparam int                CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]    CHAN_COUNT = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0]  PTR_INIT   = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t           state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [CNT_W-1:0] cnt_r;

  logic             slot_free_s;
  logic             mask_any_s;
  logic             sel_ok_s;
  logic [SEL_W-1:0] target_s;
  logic [WIDTH-1:0] chan_word [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign chan_word[k] = i_Data[k*WIDTH +: WIDTH];
  end

  // First enabled channel after 'from', wrapping at CHANNELS; may return 'from' itself.
  function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0]    from,
                                                    input logic [CHANNELS-1:0] mask);
    logic [SEL_W-1:0] pick;
    logic             hit;
    logic [SEL_W:0]   idx;
    pick = from;
    hit  = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = {1'b0, from} + (SEL_W + 1)'(i);
      if (idx >= CHAN_COUNT) begin
        idx = idx - CHAN_COUNT;
      end else begin
        idx = idx;
      end
      if (!hit && mask[idx[SEL_W-1:0]]) begin
        pick = idx[SEL_W-1:0];
        hit  = 1'b1;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Handshake slot, manual select qualification and scan target search.
  always_comb begin
    slot_free_s = !o_Valid || i_Ready;
    mask_any_s  = |i_Mask;
    target_s    = next_enabled(ptr_r, i_Mask);
    if ({1'b0, i_Sel} < CHAN_COUNT) begin
      sel_ok_s = i_Mask[i_Sel];
    end else begin
      sel_ok_s = 1'b0;
    end
  end

  // Scan sequencer and output register; a free slot without a capture drops o_Valid.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= PTR_INIT;
      cnt_r   <= '0;
      o_Data  <= '0;
      o_Chan  <= '0;
      o_Valid <= 1'b0;
    end else begin
      if (slot_free_s) begin
        o_Valid <= 1'b0;
      end
      if (!i_Mode) begin
        state_r <= ST_IDLE;
        cnt_r   <= '0;
        if (slot_free_s && sel_ok_s) begin
          o_Data  <= chan_word[i_Sel];
          o_Chan  <= i_Sel;
          o_Valid <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (mask_any_s) begin
              state_r <= ST_DWELL;
              cnt_r   <= CNT_RELOAD;
            end
          end
          ST_DWELL: begin
            if (!mask_any_s) begin
              state_r <= ST_IDLE;
            end else if (cnt_r == '0) begin
              state_r <= ST_ISSUE;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
          ST_ISSUE: begin
            // Under backpressure the target is re-evaluated each cycle until the slot frees.
            if (!mask_any_s) begin
              state_r <= ST_IDLE;
            end else if (slot_free_s) begin
              o_Data  <= chan_word[target_s];
              o_Chan  <= target_s;
              o_Valid <= 1'b1;
              ptr_r   <= target_s;
              cnt_r   <= CNT_RELOAD;
              state_r <= ST_DWELL;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Self-checking bench: three parameterisations run in lockstep against a
// behavioural model of the sampling rules, plus directed scenario checks.
module tb_mux_scan_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  sel;
  logic        mode;
  logic [7:0]  mask;
  logic        ready;
  logic [15:0] chv [8];

  logic [63:0] data0;
  logic [47:0] data1;
  logic [79:0] data2;
  logic [7:0]  od0, od1;
  logic [15:0] od2;
  logic [2:0]  oc0, oc1, oc2;
  logic        ov0, ov1, ov2;

  always_comb begin
    for (int k = 0; k < 8; k++) data0[k*8 +: 8] = chv[k][7:0];
    for (int k = 0; k < 6; k++) data1[k*8 +: 8] = chv[k][7:0];
    for (int k = 0; k < 5; k++) data2[k*16 +: 16] = chv[k];
  end

  mux_scan_sampler #(.WIDTH(8), .CHANNELS(8), .DWELL(4)) u_dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Data(data0), .i_Sel(sel), .i_Mode(mode),
    .i_Mask(mask), .i_Ready(ready), .o_Data(od0), .o_Chan(oc0), .o_Valid(ov0));
  mux_scan_sampler #(.WIDTH(8), .CHANNELS(6), .DWELL(4)) u_dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Data(data1), .i_Sel(sel), .i_Mode(mode),
    .i_Mask(mask[5:0]), .i_Ready(ready), .o_Data(od1), .o_Chan(oc1), .o_Valid(ov1));
  mux_scan_sampler #(.WIDTH(16), .CHANNELS(5), .DWELL(1)) u_dut2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Data(data2), .i_Sel(sel), .i_Mode(mode),
    .i_Mask(mask[4:0]), .i_Ready(ready), .o_Data(od2), .o_Chan(oc2), .o_Valid(ov2));

  localparam int CH [3]    = '{8, 6, 5};
  localparam int DW [3]    = '{4, 4, 1};
  localparam int DMASK [3] = '{255, 255, 65535};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rec      = 1'b0;

  // Model state: wait = -1 idle, >0 cycles still to dwell, 0 ready to issue.
  bit m_valid [3];
  int m_data  [3];
  int m_chan  [3];
  int m_wait  [3];
  int m_ptr   [3];
  bit last_v  [3];
  bit free_v  [3];

  int capc0[$], capt0[$], capc2[$], capt2[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] get_valid(input int d);
    case (d)
      0:       return 32'(ov0);
      1:       return 32'(ov1);
      default: return 32'(ov2);
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int d);
    case (d)
      0:       return 32'(od0);
      1:       return 32'(od1);
      default: return 32'(od2);
    endcase
  endfunction

  function automatic logic [31:0] get_chan(input int d);
    case (d)
      0:       return 32'(oc0);
      1:       return 32'(oc1);
      default: return 32'(oc2);
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = 0;
      m_chan[d]  = 0;
      m_wait[d]  = -1;
      m_ptr[d]   = CH[d] - 1;
      last_v[d]  = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    int c, mk, s, pick;
    bit slot, cap, found;
    c     = CH[d];
    mk    = int'(mask) & ((1 << c) - 1);
    s     = int'(sel);
    slot  = !m_valid[d] || ready;
    cap   = 1'b0;
    pick  = 0;
    found = 1'b0;
    if (!mode) begin
      m_wait[d] = -1;
      if (s < c && ((mk >> s) & 1) != 0) begin
        cap  = 1'b1;
        pick = s;
      end
    end else if (mk == 0) begin
      m_wait[d] = -1;
    end else if (m_wait[d] < 0) begin
      m_wait[d] = DW[d];
    end else if (m_wait[d] > 0) begin
      m_wait[d] = m_wait[d] - 1;
    end else if (slot) begin
      for (int k = 1; k <= c; k++) begin
        if (!found && ((mk >> ((m_ptr[d] + k) % c)) & 1) != 0) begin
          pick  = (m_ptr[d] + k) % c;
          found = 1'b1;
        end
      end
      cap       = 1'b1;
      m_ptr[d]  = pick;
      m_wait[d] = DW[d];
    end
    if (slot) begin
      m_valid[d] = cap;
      if (cap) begin
        m_data[d] = int'(chv[pick]) & DMASK[d];
        m_chan[d] = pick;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) free_v[d] = !last_v[d] || ready;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) model_step(d);
    end
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("dut%0d_valid", d), get_valid(d), 32'(m_valid[d]));
      if (m_valid[d]) begin
        check_eq($sformatf("dut%0d_data", d), get_data(d), 32'(m_data[d]));
        check_eq($sformatf("dut%0d_chan", d), get_chan(d), 32'(m_chan[d]));
      end
      last_v[d] = get_valid(d) != 32'd0;
    end
    if (rec) begin
      if (ov0 && free_v[0]) begin capc0.push_back(int'(oc0)); capt0.push_back(cyc); end
      if (ov2 && free_v[2]) begin capc2.push_back(int'(oc2)); capt2.push_back(cyc); end
    end
  endtask

  task automatic reset_cycle();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst%0d_valid", d), get_valid(d), 32'd0);
      check_eq($sformatf("rst%0d_data", d), get_data(d), 32'd0);
      check_eq($sformatf("rst%0d_chan", d), get_chan(d), 32'd0);
    end
    tick();
    tick();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic clear_caps();
    capc0.delete(); capt0.delete(); capc2.delete(); capt2.delete();
  endtask

  task automatic wait_capture0();
    for (int i = 0; i < 20 && !(ov0 && free_v[0]); i++) tick();
    check_eq("capture_sync", 32'(ov0), 32'd1);
  endtask

  int rr [4] = '{0, 2, 5, 7};

  initial begin
    rst_n = 1'b1;
    sel   = 3'd0;
    mode  = 1'b0;
    mask  = 8'hFF;
    ready = 1'b1;
    for (int k = 0; k < 8; k++) chv[k] = 16'h00A0 + 16'(k);
    model_reset();
    reset_cycle();

    // Manual sweep with an asynchronous reset in the middle.
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      tick();
      check_eq("sweep_data", 32'(od0), 32'hA0 + 32'(k));
      check_eq("sweep_chan", 32'(oc0), 32'(k));
      check_eq("sweep_valid", 32'(ov0), 32'd1);
      if (k == 4) reset_cycle();
    end

    // Masked select and out-of-range select.
    mask = 8'hFE; sel = 3'd0;
    tick();
    check_eq("masked_valid0", 32'(ov0), 32'd0);
    check_eq("masked_valid2", 32'(ov2), 32'd0);
    mask = 8'hFF; sel = 3'd7;
    tick();
    check_eq("range_valid1", 32'(ov1), 32'd0);
    check_eq("range_valid2", 32'(ov2), 32'd0);
    check_eq("range_chan0", 32'(oc0), 32'd7);

    // Round-robin scan over 0,2,5,7.
    reset_cycle();
    mode = 1'b1; mask = 8'hA5; ready = 1'b1;
    clear_caps(); rec = 1'b1;
    repeat (40) tick();
    rec = 1'b0;
    check_eq("rr_count", 32'(capc0.size() >= 6), 32'd1);
    for (int i = 0; i < capc0.size(); i++) begin
      check_eq("rr_chan", 32'(capc0[i]), 32'(rr[i % 4]));
      if (i > 0) check_eq("rr_gap", 32'(capt0[i] - capt0[i-1]), 32'd5);
    end

    // Five channels, DWELL=1 instance wraps 4->0 every 2 cycles.
    reset_cycle();
    mask = 8'h1F;
    clear_caps(); rec = 1'b1;
    repeat (30) tick();
    rec = 1'b0;
    check_eq("p5_count", 32'(capc2.size() >= 10), 32'd1);
    for (int i = 0; i < capc2.size(); i++) begin
      check_eq("p5_chan", 32'(capc2[i]), 32'(i % 5));
      if (i > 0) check_eq("p5_gap", 32'(capt2[i] - capt2[i-1]), 32'd2);
    end
    for (int i = 1; i < capc0.size(); i++) check_eq("p5_gap0", 32'(capt0[i] - capt0[i-1]), 32'd5);

    // Backpressure stall: no channel skipped on release.
    mask = 8'hFF;
    clear_caps(); rec = 1'b1;
    repeat (8) tick();
    ready = 1'b0;
    repeat (20) tick();
    ready = 1'b1;
    repeat (20) tick();
    rec = 1'b0;
    check_eq("bp_count", 32'(capc0.size() >= 3), 32'd1);
    for (int i = 1; i < capc0.size(); i++) check_eq("bp_succ0", 32'(capc0[i]), 32'((capc0[i-1] + 1) % 8));
    for (int i = 1; i < capc2.size(); i++) check_eq("bp_succ2", 32'(capc2[i]), 32'((capc2[i-1] + 1) % 5));

    // Single enabled channel, then mask cleared mid-dwell.
    mask = 8'h10;
    clear_caps(); rec = 1'b1;
    repeat (25) tick();
    check_eq("single_count", 32'(capc0.size() >= 3), 32'd1);
    foreach (capc0[i]) check_eq("single_chan0", 32'(capc0[i]), 32'd4);
    foreach (capc2[i]) check_eq("single_chan2", 32'(capc2[i]), 32'd4);
    wait_capture0();
    tick(); tick();
    mask = 8'h00;
    clear_caps();
    repeat (12) tick();
    rec = 1'b0;
    check_eq("mask0_caps", 32'(capc0.size()), 32'd0);
    check_eq("mask0_valid", 32'(ov0), 32'd0);

    // Mode switch mid-dwell: manual capture on the next free cycle.
    mask = 8'hFF; rec = 1'b1;
    wait_capture0();
    rec = 1'b0;
    tick(); tick();
    mode = 1'b0; sel = 3'd3; chv[3] = 16'h5A3C;
    tick();
    check_eq("switch_chan", 32'(oc0), 32'd3);
    check_eq("switch_data", 32'(od0), 32'h3C);
    check_eq("switch_valid", 32'(ov0), 32'd1);
    mode = 1'b1;
    repeat (12) tick();

    // Randomised mixed traffic against the model.
    for (int n = 0; n < 600; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      sel   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      chv[$urandom_range(0, 7)] = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
